// File: rtl/redun_mont_pkg.sv
// redun_mont_pkg: shared types and constants for the redundant-form
// Montgomery repeated-squaring engine and its iteration controller.
//   redun0_t          - redundant-form operand (NUM_WRDS words of WRD_BITS)
//   iter_ctl_state_t  - one-hot state encoding of redun_mont_iter_ctl
//   ITER_BITS_DEFAULT - default width of iteration counts
//   ENG_RECOV_CYC     - worst-case extra cycles of the engine overflow-recovery path
//   ITER_TIMEOUT_DEFAULT - default pulse-to-pulse watchdog, ample margin over recovery
package redun_mont_pkg;

  localparam int NUM_WRDS = 4;
  localparam int WRD_BITS = 17;

  typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] redun0_t;

  localparam int ITER_BITS_DEFAULT    = 64;
  localparam int ENG_RECOV_CYC        = 8;
  localparam int ITER_TIMEOUT_DEFAULT = 8 * ENG_RECOV_CYC;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_LOAD   = 5'b00010,
    ST_RUN    = 5'b00100,
    ST_FLUSH  = 5'b01000,
    ST_RESULT = 5'b10000
  } iter_ctl_state_t;

endpackage

// File: rtl/redun_mont_iter_cnt.sv
// redun_mont_iter_cnt: iteration counter and inactivity watchdog for the
// repeated-squaring controller.
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_clr         - clear both counters (job load)
//   i_run         - counting enabled (controller in RUN)
//   i_inc         - engine produced one iteration this cycle
//   i_term        - target iteration count T
//   o_cnt_nxt     - iteration count including this cycle's pulse
//   o_hit         - this cycle's pulse is the T-th one
//   o_timeout     - TIMEOUT_CYC consecutive cycles without a pulse end this cycle
module redun_mont_iter_cnt
  import redun_mont_pkg::*;
#(
  parameter int ITER_BITS   = ITER_BITS_DEFAULT,
  parameter int TIMEOUT_CYC = ITER_TIMEOUT_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_run,
  input  logic                 i_inc,
  input  logic [ITER_BITS-1:0] i_term,
  output logic [ITER_BITS-1:0] o_cnt_nxt,
  output logic                 o_hit,
  output logic                 o_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [ITER_BITS-1:0] cnt;
  logic [TO_W-1:0]      to_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt    <= '0;
      to_cnt <= '0;
    end else if (i_run) begin
      if (i_inc) begin
        cnt    <= o_cnt_nxt;
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign o_cnt_nxt = cnt + ITER_BITS'(i_inc);
  assign o_hit     = i_run & i_inc & (o_cnt_nxt == i_term);
  // Fires on the cycle that would make the idle count reach TIMEOUT_CYC.
  assign o_timeout = i_run & ~i_inc & (to_cnt == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/redun_mont_iter_ctl.sv
// redun_mont_iter_ctl: job sequencer for the redundant-form Montgomery
// repeated-squaring engine. Loads a start value, counts T engine iterations,
// captures the T-th result, flushes the engine and hands the result out.
//   i_clk, i_rst                      - clock, synchronous active-high reset
//   i_job_val/o_job_rdy               - job handshake
//   i_job_sq, i_job_iter              - start value and squaring count T
//   i_abort                           - cancel running job (LOAD/RUN only)
//   o_eng_rst, o_eng_sq, o_eng_val    - engine control/load
//   i_eng_mul, i_eng_val              - engine per-iteration output
//   o_res_val/i_res_rdy               - result handshake
//   o_res_dat, o_res_iter, o_res_err  - result value, iterations done, error flag
//   o_busy                            - controller not in IDLE
module redun_mont_iter_ctl
  import redun_mont_pkg::*;
#(
  parameter int ITER_BITS   = ITER_BITS_DEFAULT,
  parameter int ENG_RST_CYC = 4,
  parameter int TIMEOUT_CYC = ITER_TIMEOUT_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_job_val,
  output logic                 o_job_rdy,
  input  redun0_t              i_job_sq,
  input  logic [ITER_BITS-1:0] i_job_iter,
  input  logic                 i_abort,
  output logic                 o_eng_rst,
  output redun0_t              o_eng_sq,
  output logic                 o_eng_val,
  input  redun0_t              i_eng_mul,
  input  logic                 i_eng_val,
  output logic                 o_res_val,
  input  logic                 i_res_rdy,
  output redun0_t              o_res_dat,
  output logic [ITER_BITS-1:0] o_res_iter,
  output logic                 o_res_err,
  output logic                 o_busy
);

  localparam int FC_W = $clog2(ENG_RST_CYC + 1);

  iter_ctl_state_t      state;
  logic [ITER_BITS-1:0] job_iter;
  logic [FC_W-1:0]      fcnt;
  logic                 pend;     // a result is waiting behind the flush
  redun0_t              last_mul; // most recent engine output of this job

  logic                 cnt_clr;
  logic                 cnt_run;
  logic [ITER_BITS-1:0] cnt_nxt;
  logic                 hit;
  logic                 timeout;

  assign cnt_clr = (state == ST_LOAD);
  assign cnt_run = (state == ST_RUN);

  redun_mont_iter_cnt #(
    .ITER_BITS   (ITER_BITS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (cnt_clr),
    .i_run     (cnt_run),
    .i_inc     (i_eng_val),
    .i_term    (job_iter),
    .o_cnt_nxt (cnt_nxt),
    .o_hit     (hit),
    .o_timeout (timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Power-on and mid-job reset both flush the engine without a result.
      state      <= ST_FLUSH;
      fcnt       <= '0;
      pend       <= 1'b0;
      o_job_rdy  <= 1'b0;
      o_eng_rst  <= 1'b1;
      o_eng_val  <= 1'b0;
      o_eng_sq   <= '0;
      o_res_val  <= 1'b0;
      o_res_err  <= 1'b0;
      o_res_dat  <= '0;
      o_res_iter <= '0;
      o_busy     <= 1'b1;
      last_mul   <= '0;
      job_iter   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_job_val && o_job_rdy) begin
            job_iter  <= i_job_iter;
            o_job_rdy <= 1'b0;
            o_busy    <= 1'b1;
            if (i_job_iter == '0) begin
              // Zero squarings: the start value is the answer, engine untouched.
              o_res_dat  <= i_job_sq;
              o_res_iter <= '0;
              o_res_err  <= 1'b0;
              o_res_val  <= 1'b1;
              state      <= ST_RESULT;
            end else begin
              o_eng_sq  <= i_job_sq;
              o_eng_val <= 1'b1;
              state     <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          o_eng_val <= 1'b0;
          last_mul  <= '0;
          if (i_abort) begin
            o_res_err  <= 1'b1;
            o_res_iter <= '0;
            o_res_dat  <= '0;
            pend       <= 1'b1;
            fcnt       <= '0;
            o_eng_rst  <= 1'b1;
            state      <= ST_FLUSH;
          end else begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (hit) begin
            // Completion takes precedence over a simultaneous abort.
            o_res_dat  <= i_eng_mul;
            o_res_iter <= job_iter;
            o_res_err  <= 1'b0;
            pend       <= 1'b1;
            fcnt       <= '0;
            o_eng_rst  <= 1'b1;
            state      <= ST_FLUSH;
          end else if (i_abort || timeout) begin
            // A pulse arriving with the abort still counts as completed work.
            o_res_err  <= 1'b1;
            o_res_iter <= cnt_nxt;
            o_res_dat  <= i_eng_val ? i_eng_mul : last_mul;
            pend       <= 1'b1;
            fcnt       <= '0;
            o_eng_rst  <= 1'b1;
            state      <= ST_FLUSH;
          end else if (i_eng_val) begin
            last_mul <= i_eng_mul;
          end
        end

        ST_FLUSH: begin
          if (fcnt == FC_W'(ENG_RST_CYC - 1)) begin
            o_eng_rst <= 1'b0;
            if (pend) begin
              pend      <= 1'b0;
              o_res_val <= 1'b1;
              state     <= ST_RESULT;
            end else begin
              o_job_rdy <= 1'b1;
              o_busy    <= 1'b0;
              state     <= ST_IDLE;
            end
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end

        ST_RESULT: begin
          if (i_res_rdy) begin
            o_res_val <= 1'b0;
            o_job_rdy <= 1'b1;
            o_busy    <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_FLUSH;
          fcnt      <= '0;
          pend      <= 1'b0;
          o_eng_rst <= 1'b1;
          o_job_rdy <= 1'b0;
          o_busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_redun_mont_iter_ctl.sv
// tb_redun_mont_iter_ctl: self-checking bench for redun_mont_iter_ctl with a
// behavioural engine stub (first pulse 10 cycles after load, then every 3,
// output = start + k) and a result scoreboard.
module tb_redun_mont_iter_ctl;
  import redun_mont_pkg::*;

  localparam int IB  = 64;
  localparam int ERC = 4;
  localparam int TOC = 64;
  localparam int RB  = NUM_WRDS * WRD_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_val;
  logic          o_job_rdy;
  redun0_t       job_sq;
  logic [IB-1:0] job_iter;
  logic          abort;
  logic          o_eng_rst;
  redun0_t       o_eng_sq;
  logic          o_eng_val;
  redun0_t       eng_mul;
  logic          eng_val;
  logic          o_res_val;
  logic          res_rdy;
  redun0_t       o_res_dat;
  logic [IB-1:0] o_res_iter;
  logic          o_res_err;
  logic          o_busy;

  typedef struct {
    logic [RB-1:0] dat;
    logic [IB-1:0] iter;
    logic          err;
    bit            chk_dat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  int eng_val_cnt = 0, eng_rst_cnt = 0, res_val_cnt = 0, acc_cnt = 0;
  int eng_val_cyc = 0, last_pulse_cyc = 0, res_rise_cyc = 0, accept_cyc = 0;
  bit prev_res_val = 1'b0;

  int            stub_k = 0, stub_wait = 0, stub_stop = 0;
  bit            stub_act = 1'b0;
  logic [RB-1:0] stub_start = '0;

  redun_mont_iter_ctl #(
    .ITER_BITS   (IB),
    .ENG_RST_CYC (ERC),
    .TIMEOUT_CYC (TOC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_job_val  (job_val),
    .o_job_rdy  (o_job_rdy),
    .i_job_sq   (job_sq),
    .i_job_iter (job_iter),
    .i_abort    (abort),
    .o_eng_rst  (o_eng_rst),
    .o_eng_sq   (o_eng_sq),
    .o_eng_val  (o_eng_val),
    .i_eng_mul  (eng_mul),
    .i_eng_val  (eng_val),
    .o_res_val  (o_res_val),
    .i_res_rdy  (res_rdy),
    .o_res_dat  (o_res_dat),
    .o_res_iter (o_res_iter),
    .o_res_err  (o_res_err),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [RB-1:0] dat, input logic [IB-1:0] it,
                          input logic err, input bit chk_dat);
    exp_t x;
    x.dat = dat; x.iter = it; x.err = err; x.chk_dat = chk_dat;
    sb.push_back(x);
  endtask

  task automatic do_job(input logic [RB-1:0] sq, input logic [IB-1:0] it);
    job_sq = sq; job_iter = it; job_val = 1'b1;
    for (int i = 0; i < 100 && !o_job_rdy; i++) tick();
    check("job_acc", o_job_rdy, 1);
    tick();
    job_val = 1'b0;
  endtask

  task automatic wait_res(input int lim, input string tag);
    for (int i = 0; i < lim && !o_res_val; i++) tick();
    check(tag, o_res_val, 1);
    tick();
  endtask

  task automatic wait_rdy(input int lim, input string tag);
    for (int i = 0; i < lim && !o_job_rdy; i++) tick();
    check(tag, o_job_rdy, 1);
  endtask

  task automatic wait_pulse(input int k, input int lim, input string tag);
    for (int i = 0; i < lim && !(eng_val && stub_k == k); i++) tick();
    check(tag, (eng_val && stub_k == k), 1);
  endtask

  // Engine stub
  initial begin
    eng_val = 1'b0;
    eng_mul = '0;
    forever begin
      @(posedge clk);
      #1;
      eng_val = 1'b0;
      if (o_eng_rst) begin
        stub_act = 1'b0;
      end else if (o_eng_val) begin
        stub_act = 1'b1; stub_k = 0; stub_start = o_eng_sq; stub_wait = 10;
      end else if (stub_act) begin
        stub_wait--;
        if (stub_wait == 0) begin
          stub_k++;
          eng_val = 1'b1;
          eng_mul = stub_start + RB'(stub_k);
          stub_wait = 3;
          if (stub_stop != 0 && stub_k == stub_stop) stub_act = 1'b0;
        end
      end
    end
  end

  // Monitor and scoreboard
  always @(negedge clk) begin
    if (eng_val) last_pulse_cyc = cyc;
    if (o_eng_val) begin eng_val_cnt++; eng_val_cyc = cyc; end
    if (o_eng_rst) eng_rst_cnt++;
    if (o_res_val) res_val_cnt++;
    if (o_res_val && !prev_res_val) res_rise_cyc = cyc;
    prev_res_val = o_res_val;
    if (o_job_rdy && job_val) begin accept_cyc = cyc; acc_cnt++; end
    if (o_res_val && res_rdy) begin
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        if (e.chk_dat) check("res_dat", o_res_dat, e.dat);
        check("res_iter", o_res_iter, e.iter);
        check("res_err", o_res_err, e.err);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, acc0;
    bit stable;
    logic [RB-1:0] cap_dat;
    logic [IB-1:0] cap_iter;
    logic cap_err;

    rst = 1'b1; job_val = 1'b0; job_sq = '0; job_iter = '0; abort = 1'b0; res_rdy = 1'b1;
    repeat (3) tick();
    check("rst_job_rdy", o_job_rdy, 0);
    check("rst_eng_rst", o_eng_rst, 1);
    check("rst_eng_val", o_eng_val, 0);
    check("rst_res_val", o_res_val, 0);
    check("rst_res_err", o_res_err, 0);
    check("rst_busy", o_busy, 1);
    check("rst_res_dat", o_res_dat, 0);
    check("rst_res_iter", o_res_iter, 0);
    check("rst_eng_sq", o_eng_sq, 0);
    rst = 1'b0;
    wait_rdy(20, "por_rdy");
    check("por_busy", o_busy, 0);

    // Normal job: sq=5, T=3
    eng_val_cnt = 0; eng_rst_cnt = 0;
    push_exp(RB'(8), 3, 1'b0, 1'b1);
    do_job(RB'(5), 3);
    wait_res(100, "t1_res");
    check("t1_engval_cnt", eng_val_cnt, 1);
    check("t1_engrst_cnt", eng_rst_cnt, ERC);
    check("t1_eng_lat", eng_val_cyc - accept_cyc, 1);
    check("t1_res_lat", res_rise_cyc - last_pulse_cyc, ERC + 1);
    check("t1_eng_sq_hold", o_eng_sq, 5);

    // T=0 bypass
    eng_val_cnt = 0; eng_rst_cnt = 0;
    push_exp(RB'(16'h1234), 0, 1'b0, 1'b1);
    do_job(RB'(16'h1234), 0);
    wait_res(10, "t2_res");
    check("t2_engval_cnt", eng_val_cnt, 0);
    check("t2_engrst_cnt", eng_rst_cnt, 0);
    check("t2_res_lat", res_rise_cyc - accept_cyc, 1);

    // Engine stalls after 2 pulses -> timeout
    stub_stop = 2; eng_rst_cnt = 0;
    push_exp(RB'(102), 2, 1'b1, 1'b1);
    do_job(RB'(100), 10);
    wait_res(200, "t3_res");
    check("t3_to_lat", res_rise_cyc - last_pulse_cyc, TOC + ERC + 1);
    check("t3_engrst_cnt", eng_rst_cnt, ERC);
    stub_stop = 0;

    // Abort on pulse 4 of T=100
    push_exp('0, 4, 1'b1, 1'b0);
    do_job(RB'(7), 100);
    wait_pulse(4, 100, "t4_pulse4");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_res(50, "t4_res");

    // Abort coinciding with the T-th pulse: completion wins
    push_exp(RB'(24), 4, 1'b0, 1'b1);
    do_job(RB'(20), 4);
    wait_pulse(4, 100, "t4b_pulse4");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_res(50, "t4b_res");

    // Result back-pressure with a pending job request
    res_rdy = 1'b0;
    push_exp(RB'(52), 2, 1'b0, 1'b1);
    do_job(RB'(50), 2);
    for (int i = 0; i < 100 && !o_res_val; i++) tick();
    check("t5_res", o_res_val, 1);
    cap_dat = o_res_dat; cap_iter = o_res_iter; cap_err = o_res_err;
    push_exp(RB'(9), 0, 1'b0, 1'b1);
    job_sq = RB'(9); job_iter = 0; job_val = 1'b1;
    acc0 = acc_cnt;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (o_res_dat !== cap_dat || o_res_iter !== cap_iter || o_res_err !== cap_err ||
          o_res_val !== 1'b1 || o_job_rdy !== 1'b0) stable = 1'b0;
    end
    check("t5_stable", stable, 1);
    check("t5_no_accept", acc_cnt - acc0, 0);
    h = cyc;
    res_rdy = 1'b1;
    tick();
    check("t5_val_drop", o_res_val, 0);
    check("t5_rdy_back", o_job_rdy, 1);
    tick();
    job_val = 1'b0;
    check("t5_acc_lat", accept_cyc - h, 1);
    wait_res(10, "t5_res2");

    // Reset in the middle of RUN
    res_val_cnt = 0;
    do_job(RB'(3), 50);
    wait_pulse(2, 100, "t6_pulse2");
    eng_rst_cnt = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_rdy(20, "t6_rdy");
    check("t6_engrst_cnt", eng_rst_cnt, ERC);
    check("t6_no_res", res_val_cnt, 0);
    check("t6_busy", o_busy, 0);

    check("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
